// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// default bit-period divisor for the board clock at 115200 baud.
// UART_TX_BREAK_EN adds the BREAK and MARK states used by line-break support.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int BOARD_CLK_HZ     = 50_000_000;
   localparam int UART_BAUD        = 115_200;
   // Rounded to the nearest whole clock count per bit.
   localparam int DEFAULT_BAUD_DIV = (BOARD_CLK_HZ + UART_BAUD / 2) / UART_BAUD;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
      ,
      ST_BREAK  = 3'd5,
      ST_MARK   = 3'd6
`endif
   } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a down-counter loaded with the divisor D that flags the
// last clock of every bit period. Shared by the transmitter and receiver.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_next;

   // Counting D-1 down to 0 gives exactly D cycles per bit.
   assign o_tick = i_en && (cnt_reg == '0);

   // Next count: restart on load or at the end of each bit, else count down.
   always_comb begin
      cnt_next = cnt_reg;
      if (i_load || o_tick) begin
         cnt_next = i_div - DIV_W'(1);
      end else if (i_en) begin
         cnt_next = cnt_reg - DIV_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits (LSB first), optional
// odd/even parity, 1 or 2 stop bits; bit period taken from i_baud_div when a
// frame is accepted. Strobe/busy/done handshake.
// Optional line break support is built when UART_TX_BREAK_EN is defined.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [DIV_W-1:0]     i_baud_div,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_en,
`ifdef UART_TX_BREAK_EN
   input  logic                 i_break,
`endif
   output logic                 o_txd,
   output logic                 o_tx_busy,
   output logic                 o_tx_done
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (DIV_W < 2) begin : g_bad_div_w
      $error("uart_tx_cfg: DIV_W must be at least 2");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   uart_state_t          state_reg, state_next;
   logic [3:0]           bit_reg, bit_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_reg, par_next;
   logic [DIV_W-1:0]     div_reg, div_next;
   logic                 txd_reg, txd_next;
   logic                 done_reg, done_next;
   logic                 load;
   logic                 tick;
   logic                 busy;
   logic                 break_start;
   logic                 frame_start;
   logic [DIV_W-1:0]     eff_div;
   logic [DIV_W-1:0]     tick_div;
   logic [DATA_BITS:0]   xor_chain;
   logic                 par_bit;

   // Parity of the incoming word, folded bit by bit.
   assign xor_chain[0] = 1'b0;
   for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
      assign xor_chain[gi+1] = xor_chain[gi] ^ i_tx_data[gi];
   end
   assign par_bit = (PARITY == PAR_ODD) ? ~xor_chain[DATA_BITS] : xor_chain[DATA_BITS];

   // A divisor below 2 would make bits shorter than the counter can time.
   assign eff_div  = (i_baud_div < DIV_W'(2)) ? DIV_W'(2) : i_baud_div;
   assign tick_div = (state_reg == ST_IDLE) ? eff_div : div_reg;
   assign busy     = (state_reg != ST_IDLE);

`ifdef UART_TX_BREAK_EN
   logic min_reg, min_next;  // break has already lasted one full bit time
   assign break_start = (state_reg == ST_IDLE) && i_break;
`else
   assign break_start = 1'b0;
`endif
   // Break takes priority over data in IDLE.
   assign frame_start = (state_reg == ST_IDLE) && i_tx_en && !break_start;

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (load),
      .i_en   (busy),
      .i_div  (tick_div),
      .o_tick (tick)
   );

   // Next-state logic; the line level follows the state being entered.
   always_comb begin
      state_next = state_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      div_next   = div_reg;
      done_next  = 1'b0;
      load       = 1'b0;
      txd_next   = 1'b1;
`ifdef UART_TX_BREAK_EN
      min_next   = min_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (frame_start) begin
               state_next = ST_START;
               shift_next = i_tx_data;
               par_next   = par_bit;
               div_next   = eff_div;
               bit_next   = '0;
               load       = 1'b1;
            end
`ifdef UART_TX_BREAK_EN
            if (break_start) begin
               state_next = ST_BREAK;
               div_next   = eff_div;
               min_next   = 1'b0;
               load       = 1'b1;
            end
`endif
         end
         ST_START: begin
            if (tick) begin
               state_next = ST_DATA;
               bit_next   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_next = shift_reg >> 1;
               if (bit_reg == LAST_DATA) begin
                  bit_next   = '0;
                  state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_next = bit_reg + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_next = ST_STOP;
               bit_next   = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_reg == LAST_STOP) begin
                  state_next = ST_IDLE;
                  bit_next   = '0;
                  done_next  = 1'b1;
               end else begin
                  bit_next = bit_reg + 4'd1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            if (tick) begin
               min_next = 1'b1;
            end
            // Release only once a full bit time of low has been driven.
            if (!i_break && (tick || min_reg)) begin
               state_next = ST_MARK;
               load       = 1'b1;
            end
         end
         ST_MARK: begin
            if (tick) begin
               state_next = ST_IDLE;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
            bit_next   = '0;
         end
      endcase

      case (state_next)
         ST_START:  txd_next = 1'b0;
         ST_DATA:   txd_next = shift_next[0];
         ST_PARITY: txd_next = par_next;
`ifdef UART_TX_BREAK_EN
         ST_BREAK:  txd_next = 1'b0;
`endif
         default:   txd_next = 1'b1;
      endcase
   end

   // State, datapath and registered line outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg <= ST_IDLE;
         bit_reg   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         div_reg   <= DIV_W'(DEFAULT_BAUD_DIV);
         txd_reg   <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         div_reg   <= div_next;
         txd_reg   <= txd_next;
         done_reg  <= done_next;
      end
   end

`ifdef UART_TX_BREAK_EN
   // Minimum-length flag for the current break.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         min_reg <= 1'b0;
      end else begin
         min_reg <= min_next;
      end
   end
`endif

   assign o_txd     = txd_reg;
   assign o_tx_busy = busy;
   assign o_tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four frame formats (8N1, 8E1, 8O1, 7N2) sharing clock,
// reset, data and divisor; each has its own send strobe. Expected waveforms are
// built from the frame rules (bit list x divisor) and compared cycle by cycle.
// Break tests are included when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  en;
   logic [8:0]  data;
   logic [15:0] div;
   wire  [3:0]  txd;
   wire  [3:0]  busy;
   wire  [3:0]  done;
`ifdef UART_TX_BREAK_EN
   logic [3:0]  brk;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_8n1 (
      .i_clk(clk), .i_rstn(rstn), .i_baud_div(div), .i_tx_data(data[7:0]), .i_tx_en(en[0]),
`ifdef UART_TX_BREAK_EN
      .i_break(brk[0]),
`endif
      .o_txd(txd[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_8e1 (
      .i_clk(clk), .i_rstn(rstn), .i_baud_div(div), .i_tx_data(data[7:0]), .i_tx_en(en[1]),
`ifdef UART_TX_BREAK_EN
      .i_break(brk[1]),
`endif
      .o_txd(txd[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16)) u_8o1 (
      .i_clk(clk), .i_rstn(rstn), .i_baud_div(div), .i_tx_data(data[7:0]), .i_tx_en(en[2]),
`ifdef UART_TX_BREAK_EN
      .i_break(brk[2]),
`endif
      .o_txd(txd[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

   uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DIV_W(16)) u_7n2 (
      .i_clk(clk), .i_rstn(rstn), .i_baud_div(div), .i_tx_data(data[6:0]), .i_tx_en(en[3]),
`ifdef UART_TX_BREAK_EN
      .i_break(brk[3]),
`endif
      .o_txd(txd[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));

   // Frame format of each instance: data bits, parity mode, stop bits.
   function automatic int nbits(input int k);
      return (k == 3) ? 7 : 8;
   endfunction
   function automatic int pmode(input int k);
      case (k)
         1:       return 2;
         2:       return 1;
         default: return 0;
      endcase
   endfunction
   function automatic int nstop(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   // Reference: list the line levels of the frame, stretch each to D cycles,
   // then one done cycle (idle line, not busy, done high).
   task automatic model_frame(input int k, input logic [8:0] d, input int div_in,
                              output logic [255:0] et, output logic [255:0] eb,
                              output logic [255:0] ed, output int len);
      int dd;
      int ones;
      bit bits[$];
      dd   = (div_in < 2) ? 2 : div_in;
      ones = 0;
      et   = '0;
      eb   = '0;
      ed   = '0;
      bits.push_back(1'b0);
      for (int i = 0; i < nbits(k); i++) begin
         bits.push_back(d[i]);
         if (d[i]) ones++;
      end
      if (pmode(k) == 1) bits.push_back((ones % 2) == 0);
      if (pmode(k) == 2) bits.push_back((ones % 2) == 1);
      for (int i = 0; i < nstop(k); i++) bits.push_back(1'b1);
      len = bits.size() * dd + 1;
      for (int c = 1; c <= len; c++) begin
         et[c-1] = (c < len) ? bits[(c - 1) / dd] : 1'b1;
         eb[c-1] = (c < len);
         ed[c-1] = (c == len);
      end
   endtask

   // Send one frame on instance k starting at the current falling edge and
   // check it through its done cycle. The strobe stays high for hold_en cycles
   // (extra requests mid-frame must be ignored); the divisor input may be
   // changed at cycle chg_at to show it does not affect the frame in flight.
   task automatic run_frame(input int k, input logic [8:0] d, input int div_in,
                            input int hold_en, input int chg_at, input int chg_div);
      logic [255:0] et, eb, ed, ot, ob, od;
      int len;
      int hold;
      model_frame(k, d, div_in, et, eb, ed, len);
      hold = (hold_en > len - 1) ? len - 1 : hold_en;
      ot = '0;
      ob = '0;
      od = '0;
      data  = d;
      div   = 16'(div_in);
      en[k] = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= len; c++) begin
         ot[c-1] = txd[k];
         ob[c-1] = busy[k];
         od[c-1] = done[k];
         if (c >= hold) en[k] = 1'b0;
         if (c == chg_at) div = 16'(chg_div);
         if (c < len) @(negedge clk);
      end
      $display("[TB] frame dut=%0d data=0x%0h div=%0d cycles=%0d", k, d, div_in, len);
      tests_run++;
      if (ot !== et) begin
         tests_failed++;
         $display("FAIL frame_txd dut=%0d got=%h exp=%h", k, ot, et);
      end
      tests_run++;
      if (ob !== eb) begin
         tests_failed++;
         $display("FAIL frame_busy dut=%0d got=%h exp=%h", k, ob, eb);
      end
      tests_run++;
      if (od !== ed) begin
         tests_failed++;
         $display("FAIL frame_done dut=%0d got=%h exp=%h", k, od, ed);
      end
   endtask

   // All instances idle: line high, not busy, no done pulse.
   task automatic idle_cycles(input int n);
      logic [11:0] bad;
      bad = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bad |= {txd ^ 4'hF, busy, done};
      end
      $display("[TB] idle cycles=%0d", n);
      tests_run++;
      if (bad !== 12'h000) begin
         tests_failed++;
         $display("FAIL idle got_mask=%h exp=000", bad);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      en   = '0;
      data = '0;
      div  = 16'd4;
`ifdef UART_TX_BREAK_EN
      brk  = '0;
`endif
      repeat (3) @(negedge clk);
      $display("[TB] reset txd=%b busy=%b done=%b", txd, busy, done);
      tests_run++;
      if ({txd, busy, done} !== 12'hF00) begin
         tests_failed++;
         $display("FAIL reset_state got=%h exp=f00", {txd, busy, done});
      end
      rstn = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_8n1();
      run_frame(0, 9'h0A5, 4, 1, 0, 0);
      idle_cycles(2);
   endtask

   task automatic test_parity();
      run_frame(1, 9'h007, 3, 1, 0, 0);
      idle_cycles(1);
      run_frame(2, 9'h007, 3, 1, 0, 0);
      idle_cycles(1);
   endtask

   task automatic test_back_to_back();
      run_frame(3, 9'h055, 5, 1, 0, 0);
      run_frame(3, 9'h02A, 5, 1, 0, 0);
      idle_cycles(2);
   endtask

   task automatic test_divisor();
      run_frame(0, 9'h0C3, 0, 1, 0, 0);
      run_frame(0, 9'h03C, 1, 1, 0, 0);
      idle_cycles(1);
      run_frame(0, 9'h096, 4, 1, 10, 8);
      run_frame(0, 9'h069, 8, 1, 0, 0);
      idle_cycles(1);
   endtask

   task automatic test_reset_midframe();
      logic [2:0] after;
      data  = 9'h0A5;
      div   = 16'd4;
      en[0] = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      // Data bit 3 of 0xA5 (a zero) occupies cycles 17..20.
      repeat (17) @(negedge clk);
      tests_run++;
      if (txd[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL midframe_bit3 got=%b exp=0", txd[0]);
      end
      rstn = 1'b0;
      #1;
      after = {txd[0], busy[0], done[0]};
      $display("[TB] async reset in data bit 3 txd/busy/done=%b", after);
      tests_run++;
      if (after !== 3'b100) begin
         tests_failed++;
         $display("FAIL async_reset got=%b exp=100", after);
      end
      @(negedge clk);
      rstn = 1'b1;
      run_frame(0, 9'h03C, 4, 1, 0, 0);
      idle_cycles(1);
   endtask

   task automatic test_random();
      int k;
      for (int n = 0; n < 10; n++) begin
         k = int'($urandom_range(0, 3));
         run_frame(k, 9'($urandom), int'($urandom_range(0, 6)),
                   int'($urandom_range(1, 30)), 0, 0);
         if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
      end
      idle_cycles(1);
   endtask

`ifdef UART_TX_BREAK_EN
   // Break held for 'hold' clock edges with a data request also pending: line
   // low for max(hold, D), then high D cycles, busy throughout, never done.
   task automatic test_break(input int hold, input int dd);
      logic [255:0] et, eb, ot, ob, od;
      int low;
      int win;
      low = (hold > dd) ? hold : dd;
      win = low + dd + 4;
      et = '0; eb = '0; ot = '0; ob = '0; od = '0;
      for (int c = 1; c <= win; c++) begin
         et[c-1] = (c > low);
         eb[c-1] = (c <= low + dd);
      end
      data   = 9'($urandom);
      div    = 16'(dd);
      brk[0] = 1'b1;
      en[0]  = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= win; c++) begin
         ot[c-1] = txd[0];
         ob[c-1] = busy[0];
         od[c-1] = done[0];
         if (c == hold) begin
            brk[0] = 1'b0;
            en[0]  = 1'b0;
         end
         if (c < win) @(negedge clk);
      end
      $display("[TB] break hold=%0d div=%0d low=%0d", hold, dd, low);
      tests_run++;
      if (ot !== et) begin
         tests_failed++;
         $display("FAIL break_txd got=%h exp=%h", ot, et);
      end
      tests_run++;
      if (ob !== eb) begin
         tests_failed++;
         $display("FAIL break_busy got=%h exp=%h", ob, eb);
      end
      tests_run++;
      if (od !== '0) begin
         tests_failed++;
         $display("FAIL break_done got=%h exp=0", od);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_divisor();
      test_reset_midframe();
      test_random();
`ifdef UART_TX_BREAK_EN
      test_break(20, 4);
      test_break(1, 4);
      test_break(int'($urandom_range(1, 12)), int'($urandom_range(2, 5)));
      run_frame(0, 9'h05A, 4, 1, 0, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
